// File: rtl/if_fetch_unit.sv
// Instruction-fetch sequencer: PC register -> imem request/ready -> decode valid/ack.
// Optional fetch timeout (sticky fetch_err) is enabled by defining FETCH_TIMEOUT_EN.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h00400000,
    parameter int          TIMEOUT_CYCLES = 16,
    parameter int          TIMEOUT_W      = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    output logic [31:0] pc_next,
    output logic        pc_ena,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        stall,
    input  logic        instr_ack,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic        instr_valid
`ifdef FETCH_TIMEOUT_EN
    ,
    output logic        fetch_err
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    if ((1 << TIMEOUT_W) <= TIMEOUT_CYCLES) begin : g_bad_cfg
        $error("TIMEOUT_W too narrow for TIMEOUT_CYCLES");
    end

    state_t      r_state, w_state_nxt;
    logic [31:0] r_instr_out;
    logic [31:0] r_instr_pc;
    logic        r_instr_valid;
    logic        w_redirect;
    logic        w_capture;
    logic        w_release;
    logic        w_unused_tgt;

    // Redirect only matters once the fetch loop is running; IDLE ignores it.
    assign w_redirect   = redirect_valid && (r_state != IDLE);
    assign w_capture    = (r_state == REQ) && imem_ready && !redirect_valid;
    assign w_release    = (r_state == HOLD) && instr_ack && !stall && !redirect_valid;
    assign w_unused_tgt = &redirect_target[1:0];

    assign imem_req    = (r_state == REQ);
    assign imem_addr   = pc_in;
    assign instr_out   = r_instr_out;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_instr_valid;

    always_comb begin
        w_state_nxt = r_state;
        pc_ena      = 1'b0;
        pc_next     = pc_in + 32'd4;
        if (w_redirect) begin
            pc_ena      = 1'b1;
            pc_next     = {redirect_target[31:2], 2'b00};
            w_state_nxt = REQ;
        end else begin
            case (r_state)
                IDLE: w_state_nxt = REQ;
                REQ: begin
                    if (imem_ready) begin
                        pc_ena      = 1'b1;
                        w_state_nxt = HOLD;
                    end
                end
                HOLD: if (w_release) w_state_nxt = REQ;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_instr_out   <= 32'h0;
            r_instr_pc    <= RESET_PC;
            r_instr_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_redirect || w_release) begin
                r_instr_valid <= 1'b0;
            end else if (w_capture) begin
                r_instr_out   <= imem_rdata;
                r_instr_pc    <= pc_in;
                r_instr_valid <= 1'b1;
            end
        end
    end

`ifdef FETCH_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] r_tmo_cnt;
    logic                 r_fetch_err;

    assign fetch_err = r_fetch_err;

    // Counts consecutive un-ready REQ cycles; saturates so the sticky error cannot re-arm.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tmo_cnt   <= '0;
            r_fetch_err <= 1'b0;
        end else if (r_state != REQ || w_state_nxt != REQ) begin
            r_tmo_cnt <= '0;
        end else if (!imem_ready && r_tmo_cnt != TIMEOUT_W'(TIMEOUT_CYCLES)) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
            if (r_tmo_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) r_fetch_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed-vector bench for if_fetch_unit; timeout scenario runs only with FETCH_TIMEOUT_EN.
module tb_if_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h00400000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic [31:0] pc_next;
    logic        pc_ena;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        stall;
    logic        instr_ack;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_valid;
`ifdef FETCH_TIMEOUT_EN
    logic        fetch_err;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(16), .TIMEOUT_W(5)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .pc_next(pc_next), .pc_ena(pc_ena),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .stall(stall), .instr_ack(instr_ack),
        .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid)
`ifdef FETCH_TIMEOUT_EN
        , .fetch_err(fetch_err)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; pc_in = RST_PC; imem_ready = 1'b1; imem_rdata = 32'h20080005;
        redirect_valid = 1'b0; redirect_target = '0; stall = 1'b0; instr_ack = 1'b0;
        tick(); tick();
        checks++; if ({imem_req, instr_valid, pc_ena} !== 3'b000) begin
            errors++; $display("FAIL reset_ctl got %b want 000", {imem_req, instr_valid, pc_ena}); end
        checks++; if (instr_pc !== RST_PC || instr_out !== 32'h0) begin
            errors++; $display("FAIL reset_regs got pc=%h out=%h want pc=%h out=0", instr_pc, instr_out, RST_PC); end
        rst = 1'b1; imem_ready = 1'b0;
        settle();
        // first cycle after reset is IDLE: no request, no PC update
        checks++; if (imem_req !== 1'b0 || pc_ena !== 1'b0) begin
            errors++; $display("FAIL idle_cycle got req=%b ena=%b want 0 0", imem_req, pc_ena); end
        tick();
        imem_ready = 1'b1;
        settle();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h00400000 || pc_ena !== 1'b1 || pc_next !== 32'h00400004) begin
            errors++; $display("FAIL first_req got req=%b addr=%h ena=%b next=%h want 1 00400000 1 00400004",
                               imem_req, imem_addr, pc_ena, pc_next); end
        tick();
        imem_ready = 1'b0; pc_in = 32'h00400004;
        settle();
        checks++; if (instr_valid !== 1'b1 || instr_out !== 32'h20080005 || instr_pc !== 32'h00400000) begin
            errors++; $display("FAIL first_fetch got v=%b out=%h pc=%h want 1 20080005 00400000", instr_valid, instr_out, instr_pc); end
        checks++; if (pc_ena !== 1'b0 || imem_req !== 1'b0) begin
            errors++; $display("FAIL hold_quiet got ena=%b req=%b want 0 0", pc_ena, imem_req); end
    endtask

    task automatic test_wait_states();
        instr_ack = 1'b1;
        tick();
        instr_ack = 1'b0;
        settle();
        checks++; if (instr_valid !== 1'b0) begin
            errors++; $display("FAIL ack_drop got v=%b want 0", instr_valid); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h00400004 || pc_ena !== 1'b0) begin
                errors++; $display("FAIL wait_%0d got req=%b addr=%h ena=%b want 1 00400004 0", i, imem_req, imem_addr, pc_ena); end
            tick();
        end
        imem_ready = 1'b1; imem_rdata = 32'h8C090010;
        settle();
        checks++; if (pc_ena !== 1'b1 || pc_next !== 32'h00400008) begin
            errors++; $display("FAIL wait_done got ena=%b next=%h want 1 00400008", pc_ena, pc_next); end
        tick();
        imem_ready = 1'b0; pc_in = 32'h00400008;
        settle();
        checks++; if (instr_valid !== 1'b1 || instr_out !== 32'h8C090010 || instr_pc !== 32'h00400004) begin
            errors++; $display("FAIL wait_fetch got v=%b out=%h pc=%h want 1 8c090010 00400004", instr_valid, instr_out, instr_pc); end
    endtask

    task automatic test_stall();
        instr_ack = 1'b1; stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (instr_valid !== 1'b1 || instr_out !== 32'h8C090010 || imem_req !== 1'b0 || pc_ena !== 1'b0) begin
                errors++; $display("FAIL stall_%0d got v=%b out=%h req=%b ena=%b want 1 8c090010 0 0",
                                   i, instr_valid, instr_out, imem_req, pc_ena); end
        end
        stall = 1'b0;
        tick();
        instr_ack = 1'b0;
        settle();
        checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1) begin
            errors++; $display("FAIL stall_release got v=%b req=%b want 0 1", instr_valid, imem_req); end
    endtask

    task automatic test_redirect();
        // REQ with ready and redirect together: data discarded
        redirect_valid = 1'b1; redirect_target = 32'h00400023; imem_ready = 1'b1; imem_rdata = 32'hDEADBEEF;
        settle();
        checks++; if (pc_ena !== 1'b1 || pc_next !== 32'h00400020) begin
            errors++; $display("FAIL redir_req got ena=%b next=%h want 1 00400020", pc_ena, pc_next); end
        tick();
        redirect_valid = 1'b0; pc_in = 32'h00400020; imem_rdata = 32'h11111111;
        settle();
        checks++; if (instr_valid !== 1'b0 || instr_out !== 32'h8C090010 || imem_req !== 1'b1 || imem_addr !== 32'h00400020) begin
            errors++; $display("FAIL redir_discard got v=%b out=%h req=%b addr=%h want 0 8c090010 1 00400020",
                               instr_valid, instr_out, imem_req, imem_addr); end
        checks++; if (pc_ena !== 1'b1 || pc_next !== 32'h00400024) begin
            errors++; $display("FAIL redir_refetch got ena=%b next=%h want 1 00400024", pc_ena, pc_next); end
        tick();
        imem_ready = 1'b0; pc_in = 32'h00400024;
        settle();
        checks++; if (instr_valid !== 1'b1 || instr_out !== 32'h11111111 || instr_pc !== 32'h00400020) begin
            errors++; $display("FAIL redir_fetch got v=%b out=%h pc=%h want 1 11111111 00400020", instr_valid, instr_out, instr_pc); end
        // redirect while holding
        redirect_valid = 1'b1; redirect_target = 32'h00400023;
        settle();
        checks++; if (pc_ena !== 1'b1 || pc_next !== 32'h00400020) begin
            errors++; $display("FAIL redir_hold got ena=%b next=%h want 1 00400020", pc_ena, pc_next); end
        tick();
        redirect_valid = 1'b0; pc_in = 32'h00400020;
        settle();
        checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h00400020) begin
            errors++; $display("FAIL redir_flush got v=%b req=%b addr=%h want 0 1 00400020", instr_valid, imem_req, imem_addr); end
    endtask

    task automatic test_wrap_and_reset();
        pc_in = 32'hFFFFFFFC; imem_ready = 1'b1; imem_rdata = 32'h00000013;
        settle();
        checks++; if (pc_ena !== 1'b1 || pc_next !== 32'h00000000) begin
            errors++; $display("FAIL wrap got ena=%b next=%h want 1 00000000", pc_ena, pc_next); end
        tick();
        imem_ready = 1'b0; pc_in = 32'h00000000;
        settle();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFFFFFC) begin
            errors++; $display("FAIL wrap_fetch got v=%b pc=%h want 1 fffffffc", instr_valid, instr_pc); end
        // redirect while the reset-released FSM would otherwise be IDLE is checked below
        rst = 1'b0;
        settle();
        checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr_pc !== RST_PC) begin
            errors++; $display("FAIL async_reset_hold got req=%b v=%b pc=%h want 0 0 00400000", imem_req, instr_valid, instr_pc); end
        tick();
        rst = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h00001000;
        settle();
        checks++; if (pc_ena !== 1'b0) begin
            errors++; $display("FAIL idle_redirect got ena=%b want 0", pc_ena); end
        tick();
        redirect_valid = 1'b0;
        settle();
        checks++; if (imem_req !== 1'b1) begin
            errors++; $display("FAIL reenter_req got req=%b want 1", imem_req); end
        #2 rst = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL async_reset_req got req=%b v=%b want 0 0", imem_req, instr_valid); end
        tick();
        rst = 1'b1;
    endtask

`ifdef FETCH_TIMEOUT_EN
    task automatic test_timeout();
        pc_in = RST_PC; imem_ready = 1'b0;
        checks++; if (fetch_err !== 1'b0) begin
            errors++; $display("FAIL err_reset got %b want 0", fetch_err); end
        tick();  // IDLE -> REQ
        for (int i = 0; i < 15; i++) tick();
        checks++; if (fetch_err !== 1'b0) begin
            errors++; $display("FAIL err_early got %b want 0", fetch_err); end
        tick();
        checks++; if (fetch_err !== 1'b1 || imem_req !== 1'b1) begin
            errors++; $display("FAIL err_set got err=%b req=%b want 1 1", fetch_err, imem_req); end
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0; instr_ack = 1'b1;
        tick();
        instr_ack = 1'b0;
        checks++; if (fetch_err !== 1'b1) begin
            errors++; $display("FAIL err_sticky got %b want 1", fetch_err); end
        rst = 1'b0;
        settle();
        checks++; if (fetch_err !== 1'b0) begin
            errors++; $display("FAIL err_clear got %b want 0", fetch_err); end
        rst = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_wait_states();
        test_stall();
        test_redirect();
        test_wrap_and_reset();
`ifdef FETCH_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
